logic_op_dispatch: RTL and testbench

// Upstream sequencer for the 4-bit logic_op unit. Accepts operand pairs on a

---
 rtl/logic_op_dispatch.sv | 129 ++++++++++++
 tb/tb_logic_op_dispatch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_dispatch.sv
// Operand-pair sequencer for the 4-bit logic_op unit: buffers pairs in a small FIFO,
// issues one op at a time with a start pulse and returns the result (or a timeout abort).
module logic_op_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    output logic                     op_start,
    output logic [3:0]               op_in1,
    output logic [3:0]               op_in2,
    input  logic [3:0]               op_out,
    input  logic                     op_finish,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [3:0]               res_data,
    output logic                     res_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [3:0]    mem_a [DEPTH];
    logic [3:0]    mem_b [DEPTH];
    logic          push;
    logic          pop;

    // in_ready depends only on the registered level, so a same-cycle pop never reopens a full FIFO
    assign in_ready   = (level != FULL);
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && (level != '0);
    assign busy       = (state != S_IDLE);
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            op_start  <= 1'b0;
            op_in1    <= 4'h0;
            op_in2    <= 4'h0;
            res_valid <= 1'b0;
            res_data  <= 4'h0;
            res_err   <= 1'b0;
        end else begin
            op_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        op_in1   <= mem_a[rd_ptr];
                        op_in2   <= mem_b[rd_ptr];
                        op_start <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // finish takes priority over a timeout landing in the same cycle
                    if (op_finish) begin
                        res_data  <= op_out;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else if (timer == TMAX) begin
                        res_data  <= 4'h0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_dispatch.sv
// Directed bench for logic_op_dispatch with a behavioural AND-mode logic_op model.
module tb_logic_op_dispatch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       op_start;
    logic [3:0] op_in1;
    logic [3:0] op_in2;
    logic [3:0] op_out;
    logic       op_finish;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_err;
    logic       busy;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int model_delay = 1;
    bit model_never = 1'b0;
    int cnt;

    logic_op_dispatch #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .op_start(op_start), .op_in1(op_in1), .op_in2(op_in2),
        .op_out(op_out), .op_finish(op_finish), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // logic_op stand-in: AND of its inputs, finish model_delay cycles after the start cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 0;
            op_finish <= 1'b0;
            op_out    <= 4'h0;
        end else begin
            if (op_start) cnt <= 1;
            else if (cnt != 0) cnt <= cnt + 1;
            op_finish <= !model_never && ((op_start && model_delay == 1) ||
                         (!op_start && cnt != 0 && cnt + 1 == model_delay));
            op_out    <= op_in1 & op_in2;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; res_ready = 1'b0;
        repeat (2) tick();
        checks++;
        if ({op_start, op_in1, op_in2, res_valid, res_data, res_err, busy} !== 15'h0) begin
            errors++; $display("FAIL reset_outputs: got %h, expected 0",
                {op_start, op_in1, op_in2, res_valid, res_data, res_err, busy});
        end
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d, expected 0", fifo_level); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        in_a = 4'hC; in_b = 4'hA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (op_start !== 1'b0 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL single_n1: start=%b level=%0d, expected start=0 level=1", op_start, fifo_level);
        end
        tick();
        checks++;
        if (op_start !== 1'b1 || op_in1 !== 4'hC || op_in2 !== 4'hA || busy !== 1'b1) begin
            errors++; $display("FAIL single_issue: start=%b in1=%h in2=%h busy=%b, expected 1 C A 1",
                op_start, op_in1, op_in2, busy);
        end
        tick();
        checks++;
        if (op_start !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL single_wait: start=%b valid=%b, expected 0 0", op_start, res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 4'h8 || res_err !== 1'b0) begin
            errors++; $display("FAIL single_result: valid=%b data=%h err=%b, expected 1 8 0", res_valid, res_data, res_err);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || op_start !== 1'b0) begin
            errors++; $display("FAIL single_done: valid=%b busy=%b start=%b, expected 0 0 0", res_valid, busy, op_start);
        end
    endtask

    logic [3:0] fill_a [6] = '{4'h3, 4'h5, 4'h9, 4'hC, 4'hF, 4'h7};
    logic [3:0] fill_b [6] = '{4'h6, 4'hE, 4'hB, 4'h5, 4'hF, 4'h1};
    logic [3:0] fill_exp [5] = '{4'h2, 4'h4, 4'h9, 4'h4, 4'hF};

    task automatic test_fill();
        int accepted = 0;
        bit last_ready = 1'b1;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_a = fill_a[i]; in_b = fill_b[i]; in_valid = 1'b1;
            if (in_ready) accepted++;
            last_ready = in_ready;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (accepted != 5 || last_ready !== 1'b0) begin
            errors++; $display("FAIL fill_accept: accepted=%0d last_ready=%b, expected 5 0", accepted, last_ready);
        end
        checks++;
        if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL fill_level: level=%0d ready=%b, expected 4 0", fifo_level, in_ready);
        end
    endtask

    task automatic test_hold_stable();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || res_data !== 4'h2 || res_err !== 1'b0 || op_start !== 1'b0 || busy !== 1'b1)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_stable: %0d unstable cycles, expected 0 (valid=%b data=%h)", bad, res_valid, res_data);
        end
    endtask

    task automatic test_drain();
        int k = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 40 && k < 5; i++) begin
            if (res_valid === 1'b1) begin
                checks++;
                if (res_data !== fill_exp[k] || res_err !== 1'b0) begin
                    errors++; $display("FAIL drain_order[%0d]: data=%h err=%b, expected %h 0", k, res_data, res_err, fill_exp[k]);
                end
                k++;
            end
            tick();
        end
        checks++;
        if (k != 5) begin errors++; $display("FAIL drain_count: got %0d results, expected 5", k); end
        checks++;
        if (fifo_level !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL drain_empty: level=%0d busy=%b, expected 0 0", fifo_level, busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int early = 0;
        res_ready = 1'b0; model_never = 1'b1;
        in_a = 4'hF; in_b = 4'h3; in_valid = 1'b1; tick();
        in_a = 4'h6; in_b = 4'hC; tick();
        in_valid = 1'b0;
        ok = op_start;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = op_start; end
        checks++;
        if (!ok) begin errors++; $display("FAIL to_start: op_start=%b, expected 1 within budget", op_start); end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (res_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin errors++; $display("FAIL to_early: %0d early results, expected 0", early); end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 4'h0) begin
            errors++; $display("FAIL to_abort: valid=%b err=%b data=%h, expected 1 1 0", res_valid, res_err, res_data);
        end
        model_never = 1'b0; res_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = op_start; end
        checks++;
        if (!ok || op_in1 !== 4'h6 || op_in2 !== 4'hC) begin
            errors++; $display("FAIL to_next_issue: seen=%b in1=%h in2=%h, expected 1 6 C", ok, op_in1, op_in2);
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = res_valid; end
        checks++;
        if (!ok || res_data !== 4'h4 || res_err !== 1'b0) begin
            errors++; $display("FAIL to_next_result: seen=%b data=%h err=%b, expected 1 4 0", ok, res_data, res_err);
        end
        tick();
    endtask

    task automatic test_late_finish();
        bit ok;
        model_delay = 15; res_ready = 1'b1;
        in_a = 4'hF; in_b = 4'h5; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        ok = op_start;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = op_start; end
        repeat (15) tick();
        checks++;
        if (!ok || op_finish !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL late_setup: start_seen=%b finish=%b valid=%b, expected 1 1 0", ok, op_finish, res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_err !== 1'b0 || res_data !== 4'h5) begin
            errors++; $display("FAIL late_finish: valid=%b err=%b data=%h, expected 1 0 5", res_valid, res_err, res_data);
        end
        model_delay = 1;
        tick();
    endtask

    task automatic test_reset_mid_op();
        int stray = 0;
        model_never = 1'b1; res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_a = 4'(i + 1); in_b = 4'hF; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd3 || busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL midop_setup: level=%0d busy=%b valid=%b, expected 3 1 0", fifo_level, busy, res_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_level !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0 || op_start !== 1'b0 ||
            op_in1 !== 4'h0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL midop_async: level=%0d ready=%b busy=%b start=%b in1=%h valid=%b, expected 0 1 0 0 0 0",
                fifo_level, in_ready, busy, op_start, op_in1, res_valid);
        end
        tick();
        rst_n = 1'b1; model_never = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid !== 1'b0 || op_start !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midop_after: %0d stray cycles, expected 0", stray); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_hold_stable();
        test_drain();
        test_timeout();
        test_late_finish();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
